// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 size/sign codes and FSM encoding.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store-data shift, load extension
// and detection of misaligned or illegal size codes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  logic [31:0] w_rsh;

  assign o_wdata = i_wdata << {i_off, 3'b000};
  assign w_rsh   = i_rdata >> {i_off, 3'b000};

  // Unsigned sizes are load-only; a store carrying them is illegal.
  always_comb begin
    o_be    = 4'b0000;
    o_rdata = '0;
    o_fault = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_off;
        o_rdata = {{24{w_rsh[7]}}, w_rsh[7:0]};
      end
      F3_BU: begin
        o_be    = 4'b0001 << i_off;
        o_rdata = {24'h0, w_rsh[7:0]};
        o_fault = i_we;
      end
      F3_H: begin
        o_be    = 4'b0011 << i_off;
        o_rdata = {{16{w_rsh[15]}}, w_rsh[15:0]};
        o_fault = i_off[0];
      end
      F3_HU: begin
        o_be    = 4'b0011 << i_off;
        o_rdata = {16'h0, w_rsh[15:0]};
        o_fault = i_off[0] | i_we;
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_rdata = w_rsh;
        o_fault = |i_off;
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/ack data-memory port fed by the ALU
// effective address, with lane-aligned byte enables and load extension.
//   state  | meaning
//   S_IDLE | ready, waiting for an op
//   S_REQ  | mem_req held, waiting for mem_ack
//   S_RSP  | one-cycle response (data or fault)
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;

  logic              w_idle, w_accept;
  logic [2:0]        w_al_f3;
  logic              w_al_we;
  logic [1:0]        w_al_off;
  logic [3:0]        w_al_be;
  logic [DATA_W-1:0] w_al_wdata, w_al_rdata;
  logic              w_al_fault;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = req_valid & w_idle;

  // One aligner serves both phases: live request while idle, captured op afterwards.
  assign w_al_f3  = w_idle ? req_funct3    : r_funct3;
  assign w_al_we  = w_idle ? req_we        : r_we;
  assign w_al_off = w_idle ? req_addr[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_funct3 (w_al_f3),
    .i_we     (w_al_we),
    .i_off    (w_al_off),
    .i_wdata  (req_wdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_al_be),
    .o_wdata  (w_al_wdata),
    .o_rdata  (w_al_rdata),
    .o_fault  (w_al_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_al_fault ? S_RSP : S_REQ;
      S_REQ:   if (mem_ack)  w_next = S_RSP;
      S_RSP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_fault  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_funct3 <= req_funct3;
      r_we     <= req_we;
      r_be     <= w_al_be;
      r_wdata  <= w_al_wdata;
      r_rdata  <= '0;
      r_fault  <= w_al_fault;
    end else if (r_state == S_REQ && mem_ack && !r_we) begin
      r_rdata  <= w_al_rdata;
    end
  end

  always_comb begin
    req_ready = w_idle;
    mem_req   = (r_state == S_REQ);
    mem_we    = r_we;
    mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    mem_be    = r_be;
    mem_wdata = r_wdata;
    rsp_valid = (r_state == S_RSP);
    rsp_fault = rsp_valid & r_fault;
    rsp_rdata = rsp_valid ? r_rdata : '0;
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses queued at issue, checked when
// rsp_valid pulses; memory-port timing and contents checked inline.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, mon_e.fault});
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
      end
    end
  end

  // waits = extra mem_req cycles before the ack cycle (0 = zero-wait).
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                        input logic hold, input logic exp_fault, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    exp_t e;
    @(negedge clk);
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    e.fault = exp_fault; e.rdata = exp_rdata;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    if (exp_fault) begin
      chk("flt_no_req", {31'd0, mem_req}, 32'd0);
      chk("flt_rsp_n1", {31'd0, rsp_valid}, 32'd1);
    end else begin
      chk("req_n1", {31'd0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      if (we) chk("mem_wdata", mem_wdata, exp_wdata);
      for (int i = 0; i < waits; i++) begin
        chk("rsp_early", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("req_held", {31'd0, mem_req}, 32'd1);
        chk("addr_stable", mem_addr, addr & 32'hFFFF_FFFC);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      chk("req_drop", {31'd0, mem_req}, 32'd0);
      chk("rsp_after_ack", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("back_idle", {31'd0, req_ready}, 32'd1);
    chk("no_reaccept", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // SW, ack in second mem_req cycle
    run_op(1'b1, F3_W, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 1, 1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    // SB lane 3, zero-wait
    run_op(1'b1, F3_B, 32'h1000_0003, 32'h0000_00A5, 32'h0, 0, 1'b0, 1'b0, 4'b1000, 32'hA500_0000, 32'h0);
    // LB / LBU lane 1
    run_op(1'b0, F3_B,  32'h2000_0001, 32'h0, 32'h1234_8056, 0, 1'b0, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FF80);
    run_op(1'b0, F3_BU, 32'h2000_0001, 32'h0, 32'h1234_8056, 2, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h0000_0080);
    // LH / LHU upper half
    run_op(1'b0, F3_H,  32'h2000_0002, 32'h0, 32'h8001_0000, 1, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
    run_op(1'b0, F3_HU, 32'h2000_0002, 32'h0, 32'h8001_0000, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0000_8001);
    // Faults with req_valid held through the op
    run_op(1'b0, F3_W,   32'h2000_0002, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'b0, 32'h0, 32'h0);
    run_op(1'b1, F3_H,   32'h2000_0001, 32'h1234_5678, 32'h0, 0, 1'b1, 1'b1, 4'b0, 32'h0, 32'h0);
    run_op(1'b1, F3_BU,  32'h2000_0000, 32'h1234_5678, 32'h0, 0, 1'b1, 1'b1, 4'b0, 32'h0, 32'h0);
    run_op(1'b0, 3'b011, 32'h2000_0000, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'b0, 32'h0, 32'h0);
    // Held valid on a normal load is not re-accepted while busy
    run_op(1'b0, F3_W, 32'h3000_0004, 32'h0, 32'h5555_AAAA, 1, 1'b1, 1'b0, 4'b1111, 32'h0, 32'h5555_AAAA);

    // Reset mid-REQ aborts without a response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_req_up", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req_low", {31'd0, mem_req}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    chk("stray_ack_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);
    run_op(1'b0, F3_W, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
